// File: rtl/aire_lcd_pkg.sv
// aire_lcd_pkg: LCD command/ASCII constants, FSM encodings and helpers shared by the A/C status LCD driver.
package aire_lcd_pkg;
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] CH_V    = 8'h56;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_0    = 8'h30;
  typedef enum logic [1:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_REFRESH} state_e;
  typedef enum logic [2:0] {W_PWR, W_IDLE, W_SETUP, W_PULSE, W_WAIT} wstate_e;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic logic [7:0] lcd_digit(input logic [2:0] x);
    return CH_0 + {5'd0, x};
  endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: drives one HD44780 byte (setup, E pulse, settle wait) and times the power-up delay with the same counter.
module lcd_byte_writer
  import aire_lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_E_PULSE = 12,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 90000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);
  localparam int TMAX = imax(imax(T_POWERUP, T_CLEAR), imax(imax(T_CMD, T_E_PULSE), T_SETUP));
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] P_PWR   = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] P_SETUP = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] P_PULSE = TW'(T_E_PULSE - 1);
  localparam logic [TW-1:0] P_CMD   = TW'(T_CMD - 1);
  localparam logic [TW-1:0] P_CLEAR = TW'(T_CLEAR - 1);

  wstate_e st_q, st_d;
  logic [TW-1:0] tm_q, tm_d;
  logic e_q, e_d, rs_q, rs_d, long_q, long_d;
  logic [7:0] data_q, data_d;

  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

  // Power-up counts up from the reset value of 0; byte phases load and count down to 0.
  always_comb begin
    st_d   = st_q;
    tm_d   = tm_q;
    rs_d   = rs_q;
    data_d = data_q;
    long_d = long_q;
    done   = (st_q == W_PWR && tm_q == P_PWR) || (st_q == W_WAIT && tm_q == '0);
    case (st_q)
      W_PWR:   begin tm_d = tm_q + 1'b1; if (done) st_d = W_IDLE; end
      W_SETUP: if (tm_q == '0) begin st_d = W_PULSE; tm_d = P_PULSE; end else tm_d = tm_q - 1'b1;
      W_PULSE: if (tm_q == '0) begin st_d = W_WAIT; tm_d = long_q ? P_CLEAR : P_CMD; end else tm_d = tm_q - 1'b1;
      W_WAIT:  if (done) st_d = W_IDLE; else tm_d = tm_q - 1'b1;
      default: ;
    endcase
    if (start && (st_q == W_IDLE || done)) begin
      st_d   = W_SETUP;
      tm_d   = P_SETUP;
      rs_d   = rs;
      data_d = data;
      long_d = long_wait;
    end
    e_d = st_d == W_PULSE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= W_PWR;
      tm_q   <= '0;
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tm_q   <= tm_d;
      e_q    <= e_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      long_q <= long_d;
    end
  end
endmodule

// File: rtl/aire_lcd_driver.sv
// aire_lcd_driver: initialises a 16x2 HD44780 LCD and rewrites line 1 with the A/C speed/temp/mode/state whenever they change.
module aire_lcd_driver
  import aire_lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_E_PULSE = 12,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 90000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] vel,
  input  logic [2:0] temp,
  input  logic [2:0] mode,
  input  logic [1:0] ctl,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);
  state_e st_q, st_d;
  logic [3:0] idx_q, idx_d, nidx;
  logic [9:0] snap_q, snap_d, cur;
  logic valid_q, valid_d, busy_q, busy_d;
  logic start, rs, long_wait, done, init_phase, off;
  logic [7:0] data, cmd, rbyte;

  assign cur    = {vel, temp, mode, ctl};
  assign lcd_rw = 1'b0;
  assign busy   = busy_q;

  // nidx is the index of the byte that would be started this cycle.
  always_comb begin
    init_phase = st_q == S_PWR_WAIT || st_q == S_INIT;
    nidx = (st_q == S_INIT || st_q == S_REFRESH) ? idx_q + 4'd1 : 4'd0;
    cmd = nidx == 4'd0 ? LCD_FUNC_SET : nidx == 4'd1 ? LCD_DISP_ON : nidx == 4'd2 ? LCD_ENTRY : LCD_CLEAR;
    off = snap_q[1:0] == 2'b00;
    case (nidx)
      4'd0:    rbyte = LCD_LINE1;
      4'd1:    rbyte = CH_V;
      4'd2:    rbyte = off ? CH_DASH : lcd_digit({1'b0, snap_q[9:8]});
      4'd4:    rbyte = CH_T;
      4'd5:    rbyte = off ? CH_DASH : lcd_digit(snap_q[7:5]);
      4'd7:    rbyte = CH_M;
      4'd8:    rbyte = off ? CH_DASH : lcd_digit(snap_q[4:2]);
      4'd10:   rbyte = CH_S;
      4'd11:   rbyte = lcd_digit({1'b0, snap_q[1:0]});
      default: rbyte = CH_SP;
    endcase
    data      = init_phase ? cmd : rbyte;
    rs        = !init_phase && nidx != 4'd0;
    long_wait = init_phase && nidx == 4'd3;
  end

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    start   = 1'b0;
    case (st_q)
      S_PWR_WAIT: if (done) begin st_d = S_INIT; idx_d = '0; start = 1'b1; end
      S_INIT, S_REFRESH: if (done) begin
        if (idx_q == (st_q == S_INIT ? 4'd3 : 4'd11)) begin
          st_d    = S_IDLE;
          valid_d = valid_q || st_q == S_REFRESH;
        end else begin
          start = 1'b1;
          idx_d = nidx;
        end
      end
      default: if (!valid_q || cur != snap_q) begin
        st_d   = S_REFRESH;
        snap_d = cur;
        idx_d  = '0;
        start  = 1'b1;
      end
    endcase
    busy_d = st_d != S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q    <= S_PWR_WAIT;
      idx_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  lcd_byte_writer #(
    .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_E_PULSE(T_E_PULSE), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) u_writer (
    .clock(clock), .reset(reset), .start(start), .rs(rs), .data(data), .long_wait(long_wait),
    .done(done), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );
endmodule

// File: tb/tb_aire_lcd_driver.sv
// tb_aire_lcd_driver: checks init sequence, line-1 contents, LCD bus timing and reset behaviour of aire_lcd_driver.
module tb_aire_lcd_driver;
  localparam int T_POWERUP = 20, T_SETUP = 1, T_E_PULSE = 2, T_CMD = 4, T_CLEAR = 10;

  logic clock = 1'b0, reset = 1'b0;
  logic [1:0] vel = 2'd1, ctl = 2'd1;
  logic [2:0] temp = 3'd3, mode = 3'd2;
  logic lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  int nvec = 0, nerr = 0;
  logic [8:0] byq[$];

  typedef struct {
    logic [1:0] v;
    logic [2:0] t;
    logic [2:0] m;
    logic [1:0] c;
    logic [87:0] txt;
  } vec_t;
  vec_t tbl[5];

  aire_lcd_driver #(
    .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_E_PULSE(T_E_PULSE), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clock(clock), .reset(reset), .vel(vel), .temp(temp), .mode(mode), .ctl(ctl),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: logs every byte strobed on E and checks pulse width, setup/hold and the waits.
  logic prev_e = 1'b0, prev_b = 1'b1, have_fall = 1'b0, dropped = 1'b1, fall_clear = 1'b0;
  logic [8:0] prev_d = '0;
  int hi = 0, cnt = 0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_e = 1'b0; prev_b = 1'b1; hi = 0; have_fall = 1'b0; dropped = 1'b1;
    end else begin
      chk("lcd_rw", {31'd0, lcd_rw}, 0);
      if (lcd_e && !prev_e) begin
        byq.push_back({lcd_rs, lcd_data});
        chk("setup_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_d});
        if (have_fall && !dropped) chk("byte_gap", cnt, T_CMD + T_SETUP);
        hi = 1;
        dropped = 1'b0;
      end else if (lcd_e) begin
        hi++;
        chk("data_hold", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_d});
      end else if (prev_e) begin
        chk("e_width", hi, T_E_PULSE);
        cnt = 1;
        have_fall = 1'b1;
        fall_clear = prev_d == 9'h001;
      end else begin
        if (prev_b && !busy && have_fall)
          chk(fall_clear ? "clear_wait" : "cmd_wait", cnt, fall_clear ? T_CLEAR : T_CMD);
        if (!busy) dropped = 1'b1;
        cnt++;
      end
      prev_e = lcd_e;
      prev_b = busy;
      prev_d = {lcd_rs, lcd_data};
    end
  end

  function automatic logic [11:0][8:0] model(input logic [1:0] v, input logic [2:0] t,
                                              input logic [2:0] m, input logic [1:0] c);
    logic [11:0][8:0] r;
    logic [7:0] s[11];
    logic [7:0] dash = "-", zero = "0";
    logic off = c == 2'd0;
    s = '{"V", off ? dash : zero + 8'(v), " ", "T", off ? dash : zero + 8'(t), " ",
          "M", off ? dash : zero + 8'(m), " ", "S", zero + 8'(c)};
    r[0] = 9'h080;
    for (int i = 0; i < 11; i++) r[i+1] = {1'b1, s[i]};
    return r;
  endfunction

  function automatic logic [11:0][8:0] from_text(input logic [87:0] txt);
    logic [11:0][8:0] r;
    r[0] = 9'h080;
    for (int i = 0; i < 11; i++) r[i+1] = {1'b1, txt[87-8*i -: 8]};
    return r;
  endfunction

  task automatic wait_bytes(input int n);
    int k = 0;
    while (byq.size() < n && k < 3000) begin
      @(negedge clock);
      k++;
    end
    chk("byte_arrival", {31'd0, byq.size() >= n}, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clock);
    while (busy && k < 3000) begin
      @(negedge clock);
      k++;
    end
    chk("idle_reached", {31'd0, busy}, 0);
  endtask

  task automatic expect_bytes(input string name, input int n, input logic [11:0][8:0] e);
    logic [8:0] g;
    wait_bytes(n);
    for (int i = 0; i < n; i++) begin
      g = byq.size() != 0 ? byq.pop_front() : 9'h1ff;
      chk(name, {23'd0, g}, {23'd0, e[i]});
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [2:0] t, input logic [2:0] m, input logic [1:0] c);
    vel = v; temp = t; mode = m; ctl = c;
  endtask

  task automatic powerup_and_init();
    logic [11:0][8:0] ei = '0;
    ei[0] = 9'h038; ei[1] = 9'h00C; ei[2] = 9'h006; ei[3] = 9'h001;
    @(posedge clock);
    #2 reset = 1'b1;
    byq.delete();
    for (int i = 0; i < T_POWERUP; i++) begin
      @(negedge clock);
      chk("pwr_no_e", {31'd0, lcd_e}, 0);
    end
    chk("pwr_busy", {31'd0, busy}, 1);
    expect_bytes("init_byte", 4, ei);
  endtask

  initial begin
    logic [1:0] v, c;
    logic [2:0] t, m;
    int bhi;
    tbl[0] = '{2'd1, 3'd3, 3'd2, 2'd1, "V1 T3 M2 S1"};
    tbl[1] = '{2'd1, 3'd3, 3'd2, 2'd0, "V- T- M- S0"};
    tbl[2] = '{2'd3, 3'd7, 3'd0, 2'd2, "V3 T7 M0 S2"};
    tbl[3] = '{2'd0, 3'd0, 3'd7, 2'd3, "V0 T0 M7 S3"};
    tbl[4] = '{2'd2, 3'd5, 3'd5, 2'd0, "V- T- M- S0"};

    repeat (3) @(negedge clock);
    chk("rst_e", {31'd0, lcd_e}, 0);
    chk("rst_rs", {31'd0, lcd_rs}, 0);
    chk("rst_rw", {31'd0, lcd_rw}, 0);
    chk("rst_data", {24'd0, lcd_data}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    powerup_and_init();

    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_idle();
        apply(tbl[k].v, tbl[k].t, tbl[k].m, tbl[k].c);
      end
      expect_bytes("table_byte", 12, from_text(tbl[k].txt));
    end

    for (int k = 0; k < 16; k++) begin
      wait_idle();
      do begin
        v = 2'($urandom); t = 3'($urandom); m = 3'($urandom); c = 2'($urandom_range(0, 3));
      end while ({v, t, m, c} == {vel, temp, mode, ctl} || {v, t, m, c} == 10'b01_011_010_01);
      apply(v, t, m, c);
      expect_bytes("rand_byte", 12, model(v, t, m, c));
    end

    // Change temp while a refresh is in flight: old snapshot completes, then a new refresh follows at once.
    wait_idle();
    apply(2'd1, 3'd3, 3'd2, 2'd1);
    wait_bytes(2);
    temp = 3'd5;
    expect_bytes("mid_first", 12, model(2'd1, 3'd3, 3'd2, 2'd1));
    wait_idle();
    @(negedge clock);
    chk("rerefresh_next", {31'd0, busy}, 1);
    expect_bytes("mid_second", 12, model(2'd1, 3'd5, 3'd2, 2'd1));

    wait_idle();
    byq.delete();
    bhi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) bhi++;
    end
    chk("idle_no_bytes", byq.size(), 0);
    chk("idle_busy_cycles", bhi, 0);

    // Reset while E is high in a refresh.
    apply(2'd3, 3'd1, 3'd1, 2'd2);
    wait_bytes(3);
    begin
      int k = 0;
      while (!lcd_e && k < 100) begin
        @(negedge clock);
        k++;
      end
    end
    chk("e_high_before_reset", {31'd0, lcd_e}, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_e", {31'd0, lcd_e}, 0);
    chk("async_busy", {31'd0, busy}, 1);
    repeat (2) @(negedge clock);
    powerup_and_init();
    expect_bytes("post_reset_byte", 12, model(2'd3, 3'd1, 3'd1, 2'd2));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
